// File: rtl/dice_pkg.sv
// Shared types and helpers for the multi-die roller: FSM encoding,
// 7-segment decode and multi-nibble BCD arithmetic.
package dice_pkg;

  localparam int MAX_DIGITS = 4;
  localparam int BCD_W      = 4 * MAX_DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } roll_state_e;

  // Segment order {g,f,e,d,c,b,a}; anything that is not a decimal digit is blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b0111111;
      4'd1:    code = 7'b0000110;
      4'd2:    code = 7'b1011011;
      4'd3:    code = 7'b1001111;
      4'd4:    code = 7'b1100110;
      4'd5:    code = 7'b1101101;
      4'd6:    code = 7'b1111101;
      4'd7:    code = 7'b0000111;
      4'd8:    code = 7'b1111111;
      4'd9:    code = 7'b1101111;
      default: code = 7'b0000000;
    endcase
    return code;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] value);
    logic [BCD_W-1:0] res;
    logic             borrow;
    logic [3:0]       nib;
    res    = value;
    borrow = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      nib = value[4*i +: 4];
      if (borrow) begin
        if (nib == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = nib - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // A usable die size is non-zero with every nibble a decimal digit.
  function automatic logic bcd_ok(input logic [BCD_W-1:0] value);
    logic ok;
    ok = (value != '0);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (value[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dice_debounce.sv
// Single-channel tick-sampled debouncer: the level flips after DEB_SAMPLES
// consecutive tick samples disagree with it.
module dice_debounce
  import dice_pkg::*;
#(
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic level
);

  logic [3:0] match_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      level     <= 1'b0;
    end else if (tick) begin
      if (btn != level) begin
        if (match_cnt == 4'(DEB_SAMPLES - 1)) begin
          level     <= ~level;
          match_cnt <= '0;
        end else begin
          match_cnt <= match_cnt + 4'd1;
        end
      end else begin
        match_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dice_roller_mux.sv
// Multi-die roller: debounced channels pick a die, a BCD value cycles while
// held and freezes on release; result shown on a multiplexed 7-seg display.
//
// state | meaning
// IDLE  | result frozen; waits for a re-armed press on any channel
// ROLL  | result cycles sides..1 while the selected channel stays held
module dice_roller_mux
  import dice_pkg::*;
#(
  parameter int NUM_DICE    = 7,
  parameter int NUM_DIGITS  = 3,
  parameter logic [NUM_DICE*4*NUM_DIGITS-1:0] SIDES_BCD =
    {12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004},
  parameter int PRESCALE_W  = 10,
  parameter int DEB_SAMPLES = 3,
  parameter int SCAN_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DICE-1:0]     btn,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] result_bcd,
  output logic                    result_valid,
  output logic                    rolling
);

  localparam int RW    = 4 * NUM_DIGITS;
  localparam int SEL_W = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DICE < 1 || NUM_DICE > 8) begin : g_bad_dice
    $error("dice_roller_mux: NUM_DICE must be 1..8");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("dice_roller_mux: NUM_DIGITS must be 1..4");
  end
  if (DEB_SAMPLES < 2 || DEB_SAMPLES > 15) begin : g_bad_deb
    $error("dice_roller_mux: DEB_SAMPLES must be 2..15");
  end
  for (genvar c = 0; c < NUM_DICE; c++) begin : g_chk_sides
    if (!bcd_ok(BCD_W'(SIDES_BCD[c*RW +: RW]))) begin : g_bad_sides
      $error("dice_roller_mux: die size entry out of range");
    end
  end

  function automatic logic [RW-1:0] sides_of(input logic [SEL_W-1:0] ch);
    return SIDES_BCD[int'(ch)*RW +: RW];
  endfunction

  // Prescaler and debouncers
  logic [PRESCALE_W-1:0] prescaler;
  logic                  tick;
  logic [NUM_DICE-1:0]   deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prescaler <= '0;
    else        prescaler <= prescaler + 1'b1;
  end

  assign tick = (prescaler == '0);

  for (genvar c = 0; c < NUM_DICE; c++) begin : g_deb
    dice_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .btn   (btn[c]),
      .level (deb[c])
    );
  end

  // Roll state machine
  roll_state_e      state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt, first_high;
  logic [RW-1:0]    result_nxt;
  logic [BCD_W-1:0] dec_full;
  logic             armed, armed_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      result_bcd <= RW'(1);
      armed      <= 1'b1;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      result_bcd <= result_nxt;
      armed      <= armed_nxt;
    end
  end

  always_comb begin
    first_high = '0;
    for (int i = NUM_DICE - 1; i >= 0; i--) begin
      if (deb[i]) first_high = SEL_W'(i);
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    result_nxt   = result_bcd;
    armed_nxt    = armed;
    result_valid = 1'b0;
    dec_full     = bcd_dec(BCD_W'(result_bcd));
    case (state)
      IDLE: begin
        // A release with other channels still held must not chain into a new roll.
        if (deb == '0) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          sel_nxt    = first_high;
          result_nxt = sides_of(first_high);
          state_nxt  = ROLL;
        end
      end
      ROLL: begin
        if (deb[sel]) begin
          if (result_bcd == RW'(1)) result_nxt = sides_of(sel);
          else                      result_nxt = dec_full[RW-1:0];
        end else begin
          state_nxt    = IDLE;
          armed_nxt    = 1'b0;
          result_valid = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rolling = (state == ROLL);

  // Display scan
  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [NUM_DIGITS-1:0] show;
  logic                  higher_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (scan_cnt == '1) begin
        if (scan_idx == IDX_W'(NUM_DIGITS - 1)) scan_idx <= '0;
        else                                    scan_idx <= scan_idx + 1'b1;
      end
    end
  end

  always_comb begin
    higher_nz = 1'b0;
    show      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_nz = higher_nz | (result_bcd[4*i +: 4] != 4'd0);
      show[i]   = higher_nz | (i == 0);
    end
  end

  always_comb begin
    seg      = seg_decode(result_bcd[int'(scan_idx)*4 +: 4]);
    digit_en = '0;
    if (!rolling) digit_en[scan_idx] = show[scan_idx];
  end

endmodule

// File: tb/tb_dice_roller_mux.sv
// Directed bench for dice_roller_mux: tick-aligned presses with hand-derived
// roll values, display blanking and abort-by-reset.
module tb_dice_roller_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  btn = '0;
  logic [6:0]  seg;
  logic [2:0]  digit_en;
  logic [11:0] result_bcd;
  logic        result_valid;
  logic        rolling;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc     = 0;
  int vcount   = 0;

  localparam logic [6:0] SEG0 = 7'b0111111;
  localparam logic [6:0] SEG1 = 7'b0000110;
  localparam logic [6:0] SEG3 = 7'b1001111;
  localparam logic [6:0] SEG5 = 7'b1101101;

  // Channel 6 is widened to 128 so a full three-digit result is reachable.
  dice_roller_mux #(
    .NUM_DICE    (7),
    .NUM_DIGITS  (3),
    .SIDES_BCD   ({12'h128, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004}),
    .PRESCALE_W  (2),
    .DEB_SAMPLES (3),
    .SCAN_W      (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .seg          (seg),
    .digit_en     (digit_en),
    .result_bcd   (result_bcd),
    .result_valid (result_valid),
    .rolling      (rolling)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid) vcount++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // Returns just after an edge on which the prescaler was 0 (tick period 4).
  task automatic align();
    do clk1(); while (((ncyc - 1) % 4) != 0);
  endtask

  task automatic wait_valid(input string tag, input int limit, output int cnt);
    cnt = 0;
    do begin
      clk1();
      cnt++;
    end while (!result_valid && cnt < limit);
    check({tag, "_valid_seen"}, 32'(result_valid), 32'd1);
  endtask

  // Press aligned to a tick: level rises 12 clocks later, load on the next clock.
  // Releasing 4*m clocks after the rise gives 4*m+11 decrements in total.
  task automatic roll(input string tag, input logic [6:0] mask, input int m,
                      input logic [11:0] exp_load, input logic [11:0] exp_final);
    int cnt;
    align();
    btn = mask;
    repeat (12) clk1();
    check({tag, "_pre_rolling"}, 32'(rolling), 32'd0);
    clk1();
    check({tag, "_load"}, 32'(result_bcd), 32'(exp_load));
    check({tag, "_rolling"}, 32'(rolling), 32'd1);
    check({tag, "_digit_en_rolling"}, 32'(digit_en), 32'd0);
    repeat (4*m - 1) clk1();
    btn = '0;
    wait_valid(tag, 40, cnt);
    check({tag, "_release_latency"}, 32'(cnt), 32'd12);
    check({tag, "_final"}, 32'(result_bcd), 32'(exp_final));
    check({tag, "_rolling_at_valid"}, 32'(rolling), 32'd1);
    clk1();
    check({tag, "_valid_one_cycle"}, 32'(result_valid), 32'd0);
    check({tag, "_rolling_after"}, 32'(rolling), 32'd0);
    check({tag, "_hold"}, 32'(result_bcd), 32'(exp_final));
  endtask

  // segs packs the expected codes as {digit2, digit1, digit0}.
  task automatic scan_check(input string tag, input logic [2:0] exp_mask, input logic [20:0] segs);
    logic [2:0] seen;
    seen = '0;
    repeat (6) begin
      if (digit_en != '0) begin
        check({tag, "_onehot"}, 32'($countones(digit_en)), 32'd1);
        for (int i = 0; i < 3; i++) begin
          if (digit_en[i]) check({tag, "_seg"}, 32'(seg), 32'(segs[7*i +: 7]));
        end
      end
      seen |= digit_en;
      clk1();
    end
    check({tag, "_mask"}, 32'(seen), 32'(exp_mask));
  endtask

  initial begin
    int cnt;
    int vbefore;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ncyc  = 0;
    check("t1_result", 32'(result_bcd), 32'h001);
    check("t1_rolling", 32'(rolling), 32'd0);
    check("t1_valid", 32'(result_valid), 32'd0);
    check("t1_digit_en", 32'(digit_en), 32'b001);
    check("t1_seg", 32'(seg), 32'(SEG1));
    scan_check("t1_scan", 3'b001, {SEG0, SEG0, SEG1});

    // 2: a one-tick glitch never reaches the debounced level
    align();
    btn = 7'b0000010;
    repeat (4) clk1();
    btn = '0;
    repeat (20) clk1();
    check("t2_rolling", 32'(rolling), 32'd0);
    check("t2_result", 32'(result_bcd), 32'h001);
    check("t2_no_valid", 32'(vcount), 32'd0);

    // 3: d6, 15 decrements -> 6 - (15 mod 6) = 3
    roll("t3", 7'b0000010, 1, 12'h006, 12'h003);
    scan_check("t3_scan", 3'b001, {SEG0, SEG0, SEG3});

    // 4: d128 and d4 together -> lowest channel (d4) wins
    align();
    btn = 7'b1000001;
    repeat (13) clk1();
    check("t4_load", 32'(result_bcd), 32'h004);
    clk1(); check("t4_seq3", 32'(result_bcd), 32'h003);
    clk1(); check("t4_seq2", 32'(result_bcd), 32'h002);
    clk1(); check("t4_seq1", 32'(result_bcd), 32'h001);
    clk1(); check("t4_wrap", 32'(result_bcd), 32'h004);
    btn = 7'b0000001;
    repeat (20) clk1();
    check("t4_still_rolling", 32'(rolling), 32'd1);
    check("t4_no_valid", 32'(result_valid), 32'd0);
    // released 25 clocks after the rise: falls at +36, 35 decrements -> 4 - 3 = 1
    btn = '0;
    wait_valid("t4", 40, cnt);
    check("t4_final", 32'(result_bcd), 32'h001);
    clk1();
    check("t4_rolling_after", 32'(rolling), 32'd0);

    // 4b: release of the selected channel while another is held needs a re-arm
    align();
    btn = 7'b0000110;
    repeat (13) clk1();
    check("t4b_load", 32'(result_bcd), 32'h006);
    repeat (3) clk1();
    btn = 7'b0000100;
    wait_valid("t4b", 40, cnt);
    check("t4b_latency", 32'(cnt), 32'd12);
    check("t4b_final", 32'(result_bcd), 32'h003);
    repeat (21) clk1();
    check("t4b_no_rearm", 32'(rolling), 32'd0);
    check("t4b_hold", 32'(result_bcd), 32'h003);
    btn = '0;
    repeat (20) clk1();
    roll("t4b_fresh", 7'b0000100, 2, 12'h008, 12'h005);

    // 5: d128, 23 decrements -> 105 (inner zero shown); d20, 27 -> 13 (hundreds blanked)
    roll("t5a", 7'b1000000, 3, 12'h128, 12'h105);
    scan_check("t5a_scan", 3'b111, {SEG1, SEG0, SEG5});
    roll("t5b", 7'b0100000, 4, 12'h020, 12'h013);
    scan_check("t5b_scan", 3'b011, {SEG0, SEG1, SEG3});

    // 6: reset mid-roll aborts without a valid strobe
    align();
    btn = 7'b0001000;
    repeat (13) clk1();
    check("t6_load", 32'(result_bcd), 32'h010);
    repeat (5) clk1();
    vbefore = vcount;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_result", 32'(result_bcd), 32'h001);
    check("t6_rst_rolling", 32'(rolling), 32'd0);
    check("t6_rst_valid", 32'(result_valid), 32'd0);
    check("t6_rst_digit_en", 32'(digit_en), 32'b001);
    check("t6_rst_seg", 32'(seg), 32'(SEG1));
    btn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_valid", 32'(vcount), 32'(vbefore));
    rst_n = 1'b1;
    ncyc  = 0;
    roll("t6_fresh", 7'b0001000, 1, 12'h010, 12'h005);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
